// File: rtl/nios_display_mux_pkg.sv
// Shared constants and types for the multiplexed 7-segment display slave.
package nios_display_pkg;

  localparam int SEG_W     = 8;
  localparam int CTRL_OFS  = 0;
  localparam int BLINK_OFS = 1;
  localparam int DIG_BASE  = 2;

  // CTRL register bit positions
  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_DEC_BIT   = 1;
  localparam int CTRL_BLINK_BIT = 2;
  localparam int CTRL_SCAN_LSB  = 8;
  localparam int CTRL_PHASE_BIT = 16;

  // Active-high "all segments off"; polarity is applied at the output register
  localparam logic [SEG_W-1:0] SEG_BLANK = '0;

  typedef struct packed {
    logic blink_en;
    logic decode;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/nios_display_mux_if.sv
// Avalon-MM slave bus bundle for the display mux.
interface nios_display_mux_if #(
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/nios_display_mux_hex7seg.sv
// Combinational hex nibble to 7-segment decoder, active-high, a = bit 0.
module nios_hex7seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Fixed glyph table, lower-case b and d so they differ from 8 and 0
  always_comb begin
    unique case (nibble)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
  end

endmodule

// File: rtl/nios_display_mux.sv
// Avalon-MM slave scanning NUM_DIGITS 7-segment digits over one shared
// segment bus, with optional hex decode and per-digit blink.
module nios_display_mux
  import nios_display_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int ADDR_W         = 3,
  parameter int PRESCALE       = 50000,
  parameter int BLINK_TICKS    = 250,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  nios_display_mux_if.slave     bus,
  output logic [SEG_W-1:0]      seg_out,
  output logic [NUM_DIGITS-1:0] digit_sel
);

  localparam int PRE_W  = $clog2(PRESCALE);
  localparam int BLK_W  = $clog2(BLINK_TICKS + 1);
  localparam int SCAN_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [ADDR_W-1:0]     A_CTRL   = ADDR_W'(CTRL_OFS);
  localparam logic [ADDR_W-1:0]     A_BLINK  = ADDR_W'(BLINK_OFS);
  localparam logic [SEG_W-1:0]      SEG_IDLE = (SEG_ACTIVE_LOW != 0) ? ~SEG_BLANK : SEG_BLANK;
  localparam logic [NUM_DIGITS-1:0] DIG_IDLE = (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

  ctrl_t                              ctrl_q;
  logic [NUM_DIGITS-1:0]              blink_q;
  logic [NUM_DIGITS-1:0][SEG_W-1:0]   dig_q;
  logic [PRE_W-1:0]                   presc_q;
  logic [SCAN_W-1:0]                  scan_q;
  logic [BLK_W-1:0]                   bcnt_q;
  logic                               phase_q;

  logic                               wr, ctrl_wr, en_d, tick;
  logic [NUM_DIGITS-1:0][6:0]         hex_seg;
  logic [SEG_W-1:0]                   pat;
  logic [NUM_DIGITS-1:0]              sel_oh;
  logic [31:0]                        rd_data;
  logic                               unused_wdata;

  assign wr      = bus.chipselect && !bus.write_n;
  assign ctrl_wr = wr && (bus.address == A_CTRL);
  // Enable as it will be after this edge: a disabling write wins over a tick
  assign en_d    = ctrl_wr ? bus.writedata[CTRL_EN_BIT] : ctrl_q.en;
  assign tick    = ctrl_q.en && (presc_q == PRE_W'(PRESCALE - 1));

  assign unused_wdata = ^bus.writedata[31:SEG_W];

  // Register bank: host writes, unused data bits dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q  <= '0;
      blink_q <= '0;
      dig_q   <= '0;
    end else if (wr) begin
      if (bus.address == A_CTRL) begin
        ctrl_q.en       <= bus.writedata[CTRL_EN_BIT];
        ctrl_q.decode   <= bus.writedata[CTRL_DEC_BIT];
        ctrl_q.blink_en <= bus.writedata[CTRL_BLINK_BIT];
      end
      if (bus.address == A_BLINK)
        blink_q <= bus.writedata[NUM_DIGITS-1:0];
      for (int k = 0; k < NUM_DIGITS; k++)
        if (bus.address == ADDR_W'(DIG_BASE + k))
          dig_q[k] <= bus.writedata[SEG_W-1:0];
    end
  end

  // Prescaler, scan index and blink phase; all parked at 0 while disabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      scan_q  <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else if (!en_d) begin
      presc_q <= '0;
      scan_q  <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else if (ctrl_q.en) begin
      if (tick) begin
        presc_q <= '0;
        scan_q  <= (scan_q == SCAN_W'(NUM_DIGITS - 1)) ? '0 : scan_q + 1'b1;
        if (bcnt_q == BLK_W'(BLINK_TICKS - 1)) begin
          bcnt_q  <= '0;
          phase_q <= ~phase_q;
        end else begin
          bcnt_q <= bcnt_q + 1'b1;
        end
      end else begin
        presc_q <= presc_q + 1'b1;
      end
    end
  end

  // One decoder per digit; the scan mux then picks the active one
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_hex
    nios_hex7seg u_hex (
      .nibble (dig_q[g][3:0]),
      .seg    (hex_seg[g])
    );
  end

  // Active-high pattern and one-hot select for the current scan index
  always_comb begin
    pat    = SEG_BLANK;
    sel_oh = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (scan_q == SCAN_W'(k)) begin
        sel_oh[k] = 1'b1;
        pat       = ctrl_q.decode ? {dig_q[k][SEG_W-1], hex_seg[k]} : dig_q[k];
        if (ctrl_q.blink_en && blink_q[k] && phase_q)
          pat = SEG_BLANK;
      end
    end
  end

  // Output registers: segments and select always move on the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_out   <= SEG_IDLE;
      digit_sel <= DIG_IDLE;
    end else if (ctrl_q.en && en_d) begin
      seg_out   <= (SEG_ACTIVE_LOW != 0) ? ~pat : pat;
      digit_sel <= (DIG_ACTIVE_LOW != 0) ? ~sel_oh : sel_oh;
    end else begin
      seg_out   <= SEG_IDLE;
      digit_sel <= DIG_IDLE;
    end
  end

  // Zero-wait-state read mux, fields zero-extended
  always_comb begin
    rd_data = '0;
    if (bus.address == A_CTRL) begin
      rd_data[CTRL_EN_BIT]              = ctrl_q.en;
      rd_data[CTRL_DEC_BIT]             = ctrl_q.decode;
      rd_data[CTRL_BLINK_BIT]           = ctrl_q.blink_en;
      rd_data[CTRL_SCAN_LSB +: SCAN_W]  = scan_q;
      rd_data[CTRL_PHASE_BIT]           = phase_q;
    end
    if (bus.address == A_BLINK)
      rd_data[NUM_DIGITS-1:0] = blink_q;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (bus.address == ADDR_W'(DIG_BASE + k))
        rd_data[SEG_W-1:0] = dig_q[k];
  end

  assign bus.readdata = rd_data;

endmodule
